// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding,
// default counts and the timer-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    PWRDOWN   = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 100000;
  localparam int unsigned DEF_SETTLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES    = 3;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  // Wide enough to hold (largest count - 1); the timer only ever compares against N-1.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// 1-bit multi-flop synchroniser, async active-low reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-settle sequencer gating the downstream counters.
// Optional retry limit with FAULT state: define PLL_RETRY_LIMIT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int          SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       pll_locked,
  input  logic       pwrdwn_req,
  input  logic       cnt_en_req,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       cnt_rst,
  output logic       cnt_en,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_o
);
  localparam int unsigned TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  logic locked_s, pwrdwn_s, en_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(pll_locked), .q(locked_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pwr (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(pwrdwn_req), .q(pwrdwn_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(cnt_en_req), .q(en_s));

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pll_rst_q, pll_rst_d;
  logic          pll_pwrdwn_q, pll_pwrdwn_d;
  logic          cnt_rst_q, cnt_rst_d;
  logic          ready_q, ready_d;

`ifdef PLL_RETRY_LIMIT_EN
  localparam int unsigned   RW         = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  logic [RW-1:0] retries_q, retries_d;
  logic          fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_HOLD:  if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) state_d = SETTLE;
        else if (timer_q == LOCK_LAST) begin
`ifdef PLL_RETRY_LIMIT_EN
          state_d = (retries_q == RETRY_LAST) ? FAULT : RST_HOLD;
`else
          state_d = RST_HOLD;
`endif
        end
      end
      SETTLE: begin
        if (!locked_s)                    state_d = RST_HOLD;
        else if (timer_q == SETTLE_LAST)  state_d = RUN;
      end
      RUN:     if (!locked_s) state_d = RST_HOLD;
      PWRDOWN: if (!pwrdwn_s) state_d = RST_HOLD;
`ifdef PLL_RETRY_LIMIT_EN
      FAULT:   state_d = FAULT;
`endif
      default: state_d = RST_HOLD;
    endcase

    // Power-down wins over every other exit of the active states; FAULT ignores it.
    if (pwrdwn_s && (state_q == RST_HOLD || state_q == WAIT_LOCK ||
                     state_q == SETTLE   || state_q == RUN))
      state_d = PWRDOWN;

    if (state_d != state_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + TW'(1);

    pll_rst_d    = (state_d == RST_HOLD) || (state_d == PWRDOWN) || (state_d == FAULT);
    pll_pwrdwn_d = (state_d == PWRDOWN);
    cnt_rst_d    = (state_d != RUN);
    ready_d      = (state_d == RUN);

`ifdef PLL_RETRY_LIMIT_EN
    retries_d = retries_q;
    if (state_q == WAIT_LOCK && state_d == RST_HOLD) retries_d = retries_q + RW'(1);
    else if (state_q != RUN && state_d == RUN)       retries_d = '0;
    fault_d = (state_d == FAULT);
`endif
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= RST_HOLD;
      timer_q      <= '0;
      pll_rst_q    <= 1'b1;
      pll_pwrdwn_q <= 1'b0;
      cnt_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
      retries_q    <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pll_rst_q    <= pll_rst_d;
      pll_pwrdwn_q <= pll_pwrdwn_d;
      cnt_rst_q    <= cnt_rst_d;
      ready_q      <= ready_d;
`ifdef PLL_RETRY_LIMIT_EN
      retries_q    <= retries_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign pll_rst    = pll_rst_q;
  assign pll_pwrdwn = pll_pwrdwn_q;
  assign cnt_rst    = cnt_rst_q;
  assign ready      = ready_q;
  assign state_o    = state_q;
  // Enable drops on the same edge that leaves RUN, with no extra register delay.
  assign cnt_en     = (state_q == RUN) & en_s;
`ifdef PLL_RETRY_LIMIT_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table for the main sequence
// plus hand sequences for power-down, async reset and lock-timeout corners.
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n, locked, pwr, en;
  logic pll_rst, pll_pwrdwn, cnt_rst, cnt_en, ready, fault;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8),
    .MAX_RETRIES(3), .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pll_locked(locked),
    .pwrdwn_req(pwr), .cnt_en_req(en),
    .pll_rst(pll_rst), .pll_pwrdwn(pll_pwrdwn), .cnt_rst(cnt_rst),
    .cnt_en(cnt_en), .ready(ready), .fault(fault), .state_o(state_o)
  );

  // {pll_rst, pll_pwrdwn, cnt_rst, cnt_en, ready, fault, state[2:0]}
  localparam logic [8:0] E_HOLD  = 9'b1_0_1_0_0_0_000;
  localparam logic [8:0] E_WAIT  = 9'b0_0_1_0_0_0_001;
  localparam logic [8:0] E_SETL  = 9'b0_0_1_0_0_0_010;
  localparam logic [8:0] E_RUN0  = 9'b0_0_0_0_1_0_011;
  localparam logic [8:0] E_RUN1  = 9'b0_0_0_1_1_0_011;
  localparam logic [8:0] E_PWR   = 9'b1_1_1_0_0_0_100;
  localparam logic [8:0] E_FAULT = 9'b1_0_1_0_0_1_101;

  typedef struct {
    logic       lk, pw, en;
    int         n;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {pll_rst, pll_pwrdwn, cnt_rst, cnt_en, ready, fault, state_o};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Async reset pulse placed mid-cycle; outputs must drop before any clock edge.
  task automatic rst_pulse(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, E_HOLD);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; locked = 1'b0; pwr = 1'b0; en = 1'b0;

    // Edge counts below are relative to reset release (E0).
    vq.push_back('{0, 0, 0, 0, E_HOLD, "rel_hold"});
    vq.push_back('{0, 0, 0, 3, E_HOLD, "hold_e3"});
    vq.push_back('{0, 0, 0, 1, E_WAIT, "wait_e4"});
    vq.push_back('{0, 0, 0, 5, E_WAIT, "wait_e9"});
    vq.push_back('{1, 0, 0, 2, E_WAIT, "lock_sync"});
    vq.push_back('{1, 0, 0, 1, E_SETL, "settle_in"});
    vq.push_back('{1, 0, 0, 7, E_SETL, "settle_7"});
    vq.push_back('{1, 0, 0, 1, E_RUN0, "run_in"});
    vq.push_back('{1, 0, 1, 1, E_RUN0, "en_sync1"});
    vq.push_back('{1, 0, 1, 1, E_RUN1, "en_on"});
    vq.push_back('{1, 0, 0, 1, E_RUN1, "en_off_sync"});
    vq.push_back('{1, 0, 0, 1, E_RUN0, "en_off"});
    vq.push_back('{1, 0, 1, 2, E_RUN1, "en_on2"});
    vq.push_back('{0, 0, 1, 2, E_RUN1, "unlock_sync"});
    vq.push_back('{0, 0, 1, 1, E_HOLD, "unlock_hold"});
    vq.push_back('{0, 0, 1, 3, E_HOLD, "rehold_e3"});
    vq.push_back('{0, 0, 1, 1, E_WAIT, "rehold_done"});

    tick(3);
    check("in_reset", E_HOLD);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      locked = vq[i].lk; pwr = vq[i].pw; en = vq[i].en;
      tick(vq[i].n);
      check(vq[i].name, vq[i].exp);
    end

    // Power-down requested during SETTLE, then released: sequence restarts.
    locked = 1'b1;
    tick(3);  check("pd_settle", E_SETL);
    pwr = 1'b1;
    tick(2);  check("pd_sync", E_SETL);
    tick(1);  check("pd_enter", E_PWR);
    tick(5);  check("pd_hold", E_PWR);
    pwr = 1'b0;
    tick(2);  check("pd_rel_sync", E_PWR);
    tick(1);  check("pd_exit", E_HOLD);
    tick(3);  check("pd_hold_e3", E_HOLD);
    tick(1);  check("pd_wait", E_WAIT);
    tick(1);  check("pd_settle2", E_SETL);
    tick(8);  check("pd_run", E_RUN1);

    // Async reset mid-RUN and mid-SETTLE; lock and enable stay asserted.
    rst_pulse("rst_run");
    tick(4);  check("rr_wait", E_WAIT);
    tick(1);  check("rr_settle", E_SETL);
    tick(3);  check("rr_settle3", E_SETL);
    rst_pulse("rst_settle");
    tick(4);  check("rs_wait", E_WAIT);
    tick(1);  check("rs_settle", E_SETL);
    tick(8);  check("rs_run", E_RUN1);

    // Never lock: each round is 4 RST_HOLD + 20 WAIT_LOCK cycles.
    locked = 1'b0; en = 1'b0;
    rst_pulse("rst_nolock");
    tick(23); check("r1_wait_end", E_WAIT);
    tick(1);  check("r1_timeout", E_HOLD);
    tick(47); check("r3_wait_end", E_WAIT);
`ifdef PLL_RETRY_LIMIT_EN
    tick(1);  check("r3_fault", E_FAULT);
    locked = 1'b1;
    tick(50); check("fault_sticky", E_FAULT);
`else
    tick(1);  check("r3_retry", E_HOLD);
    tick(50); check("retry_forever", E_HOLD);
`endif
    rst_pulse("rst_final");
    tick(1);  check("post_rst", E_HOLD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
